// File: rtl/monitor_pkg.sv
// Shared definitions for the stage FSM and the threshold monitor:
// monitor state encoding, reserved stage codes and default bus widths.
package monitor_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    MONITOR  = 2'd1,
    ALARM    = 2'd2
  } state_t;

  localparam int MAXB_DEF   = 9;
  localparam int STAGE_DEF  = 3;
  localparam int STAGE_IDLE = 0;
  localparam int STAGE_LAST = 5;

endpackage

// File: rtl/window_timer.sv
// Free-running observation window counter: counts 0..WIN_CYCLES-1 and wraps.
// A synchronous restart forces it back to 0; last flags the final cycle.
module window_timer #(
  parameter int WIN_CYCLES = 100000000,
  parameter int WINW       = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic last
);

  localparam logic [WINW-1:0] LAST_VAL = WINW'(WIN_CYCLES - 1);

  logic [WINW-1:0] value_reg;

  // Advance every cycle, wrap after the final window cycle, restart on demand
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg <= '0;
    end else if (restart || (value_reg == LAST_VAL)) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_reg + 1'b1;
    end
  end

  assign last = (value_reg == LAST_VAL);

endmodule

// File: rtl/soglia_monitor.sv
// Threshold monitor downstream of the stage FSM. Counts activity events per
// window, compares each window against soglia, latches an alarm after
// repeated misses and requests a stage advance after repeated hits.
// Build option: EVENT_SYNC_EN adds a synchronizer and rising-edge detector
// on evento for an asynchronous event source.
module soglia_monitor #(
  parameter int MAXB       = monitor_pkg::MAXB_DEF,
  parameter int STAGE      = monitor_pkg::STAGE_DEF,
  parameter int WIN_CYCLES = 100000000,
  parameter int WINW       = 27,
  parameter int MISS_MAX   = 3,
  parameter int HIT_MAX    = 5,
  parameter int STAGE_LAST = monitor_pkg::STAGE_LAST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evento,
  input  logic [MAXB-1:0]  soglia,
  input  logic [STAGE-1:0] stage,
  input  logic             ack,
  output logic [MAXB-1:0]  conteggio,
  output logic             fine_finestra,
  output logic             allarme,
  output logic             avanza
);

  import monitor_pkg::*;

  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int HW = $clog2(HIT_MAX + 1);
  localparam logic [MW-1:0]    MISS_LIM  = MW'(MISS_MAX);
  localparam logic [HW-1:0]    HIT_LIM   = HW'(HIT_MAX);
  localparam logic [STAGE-1:0] IDLE_CODE = STAGE'(STAGE_IDLE);
  localparam logic [STAGE-1:0] LAST_CODE = STAGE'(STAGE_LAST);

  state_t           state_reg, state_next;
  logic [MAXB-1:0]  count_reg, count_next, count_sat;
  logic [MW-1:0]    miss_reg, miss_next, miss_inc;
  logic [HW-1:0]    hit_reg, hit_next, hit_inc;
  logic [STAGE-1:0] stage_q;
  logic [MAXB-1:0]  conteggio_reg, conteggio_next;
  logic             fine_reg, fine_next;
  logic             allarme_reg;
  logic             avanza_reg, avanza_next;
  logic             run;
  logic             last;
  logic             evt_qual;

`ifdef EVENT_SYNC_EN
  logic [2:0] sync_reg;
  logic       evt_reg;

  // Two synchronizer flops, one history flop, and a registered edge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
      evt_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], evento};
      evt_reg  <= sync_reg[1] & ~sync_reg[2];
    end
  end

  assign evt_qual = evt_reg;
`else
  assign evt_qual = evento;
`endif

  window_timer #(
    .WIN_CYCLES (WIN_CYCLES),
    .WINW       (WINW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (~run),
    .last    (last)
  );

  // Next-state, counter and window-evaluation logic
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    miss_next      = miss_reg;
    hit_next       = hit_reg;
    conteggio_next = conteggio_reg;
    fine_next      = 1'b0;
    avanza_next    = 1'b0;
    run            = 1'b0;

    count_sat = count_reg;
    if (evt_qual && (count_reg != '1)) begin
      count_sat = count_reg + 1'b1;
    end
    miss_inc = (miss_reg == MISS_LIM) ? miss_reg : miss_reg + 1'b1;
    hit_inc  = (hit_reg == HIT_LIM) ? hit_reg : hit_reg + 1'b1;

    if (stage == IDLE_CODE) begin
      state_next     = DISABLED;
      count_next     = '0;
      miss_next      = '0;
      hit_next       = '0;
      conteggio_next = '0;
    end else if ((state_reg == DISABLED) || (stage != stage_q)) begin
      // Leaving idle or switching stage starts a fresh window; alarm kept
      if (state_reg == DISABLED) begin
        state_next = MONITOR;
      end
      count_next = '0;
      miss_next  = '0;
      hit_next   = '0;
    end else begin
      run        = 1'b1;
      count_next = count_sat;
      if ((state_reg == ALARM) && ack) begin
        state_next = MONITOR;
        miss_next  = '0;
      end
      if (last) begin
        count_next     = '0;
        conteggio_next = count_sat;
        fine_next      = 1'b1;
        if (count_sat < soglia) begin
          hit_next  = '0;
          miss_next = miss_inc;
          // A fresh miss limit overrides a simultaneous acknowledge
          if (miss_inc == MISS_LIM) begin
            state_next = ALARM;
          end
        end else begin
          miss_next = '0;
          if ((hit_inc == HIT_LIM) && (stage != LAST_CODE)) begin
            avanza_next = 1'b1;
            hit_next    = '0;
          end else begin
            hit_next = hit_inc;
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= DISABLED;
      count_reg     <= '0;
      miss_reg      <= '0;
      hit_reg       <= '0;
      stage_q       <= '0;
      conteggio_reg <= '0;
      fine_reg      <= 1'b0;
      allarme_reg   <= 1'b0;
      avanza_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      miss_reg      <= miss_next;
      hit_reg       <= hit_next;
      stage_q       <= stage;
      conteggio_reg <= conteggio_next;
      fine_reg      <= fine_next;
      allarme_reg   <= (state_next == ALARM);
      avanza_reg    <= avanza_next;
    end
  end

  assign conteggio     = conteggio_reg;
  assign fine_finestra = fine_reg;
  assign allarme       = allarme_reg;
  assign avanza        = avanza_reg;

endmodule

// File: tb/tb_soglia_monitor.sv
// Self-checking bench for soglia_monitor with a short window (10 cycles) and
// a 3-bit event counter; a window-level reference model tracks expected
// outputs every cycle while directed scenarios check the headline behaviour.
module tb_soglia_monitor;

  localparam int MAXB   = 3;
  localparam int STAGE  = 3;
  localparam int WIN    = 10;
  localparam int WINW   = 4;
  localparam int MISS   = 3;
  localparam int HIT    = 5;
  localparam int LASTST = 5;
  localparam int SATV   = (1 << MAXB) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             evento = 1'b0;
  logic [MAXB-1:0]  soglia = '0;
  logic [STAGE-1:0] stage = '0;
  logic             ack = 1'b0;
  logic [MAXB-1:0]  conteggio;
  logic             fine_finestra;
  logic             allarme;
  logic             avanza;

  int n_pass  = 0;
  int n_total = 0;
  int mm_cnt  = 0;
  int cyc     = 0;

  // Reference model: position inside the window, events so far, run lengths
  bit m_en;
  int m_pos, m_cnt, m_miss, m_hit, m_prev;
  int e_cont;
  bit e_fine, e_alarm, e_av;

  soglia_monitor #(
    .MAXB       (MAXB),
    .STAGE      (STAGE),
    .WIN_CYCLES (WIN),
    .WINW       (WINW),
    .MISS_MAX   (MISS),
    .HIT_MAX    (HIT),
    .STAGE_LAST (LASTST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .evento        (evento),
    .soglia        (soglia),
    .stage         (stage),
    .ack           (ack),
    .conteggio     (conteggio),
    .fine_finestra (fine_finestra),
    .allarme       (allarme),
    .avanza        (avanza)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_en = 0; m_pos = 0; m_cnt = 0; m_miss = 0; m_hit = 0; m_prev = 0;
    e_cont = 0; e_fine = 0; e_alarm = 0; e_av = 0;
  endtask

  // One clock of the behavioural rules, applied to the inputs seen at the edge
  task automatic model_update();
    int c;
    bit reaches;
    e_fine  = 0;
    e_av    = 0;
    reaches = 0;
    if (!rst || stage == 0) begin
      m_en = 0; m_pos = 0; m_cnt = 0; m_miss = 0; m_hit = 0;
      e_alarm = 0; e_cont = 0;
    end else if (!m_en || int'(stage) != m_prev) begin
      m_en = 1; m_pos = 0; m_cnt = 0; m_miss = 0; m_hit = 0;
    end else begin
      c = m_cnt + int'(evento);
      if (c > SATV) c = SATV;
      if (m_pos == WIN - 1) begin
        e_cont = c; e_fine = 1; m_cnt = 0; m_pos = 0;
        if (c < int'(soglia)) begin
          m_hit  = 0;
          m_miss = (m_miss + 1 > MISS) ? MISS : m_miss + 1;
          reaches = (m_miss == MISS);
        end else begin
          m_miss = 0;
          m_hit  = m_hit + 1;
          if (m_hit >= HIT) begin
            if (int'(stage) != LASTST) begin
              e_av  = 1;
              m_hit = 0;
            end else begin
              m_hit = HIT;
            end
          end
        end
      end else begin
        m_cnt = c;
        m_pos = m_pos + 1;
      end
      if (reaches) begin
        e_alarm = 1;
      end else if (e_alarm && ack) begin
        e_alarm = 0;
        m_miss  = 0;
      end
    end
    m_prev = rst ? int'(stage) : 0;
  endtask

  // Advance one clock and note any disagreement with the model
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    if (conteggio !== e_cont[MAXB-1:0] || fine_finestra !== e_fine ||
        allarme !== e_alarm || avanza !== e_av) begin
      mm_cnt++;
      $display("cycle %0d differs: dut cont=%0d fine=%b alarm=%b av=%b, model cont=%0d fine=%b alarm=%b av=%b",
               cyc, conteggio, fine_finestra, allarme, avanza, e_cont, e_fine, e_alarm, e_av);
    end
    if (e_fine)
      $display("cycle %0d close: stage=%0d soglia=%0d conteggio=%0d allarme=%b avanza=%b",
               cyc, stage, soglia, conteggio, allarme, avanza);
  endtask

  function automatic bit [WIN-1:0] rand_mask(input int n);
    bit [WIN-1:0] m;
    int placed;
    m = '0;
    placed = 0;
    while (placed < n) begin
      int p;
      p = $urandom_range(WIN - 1, 0);
      if (!m[p]) begin
        m[p] = 1'b1;
        placed++;
      end
    end
    return m;
  endfunction

  // Drive one full window from its first cycle; events follow mask by position
  task automatic run_window(input bit [WIN-1:0] mask, input bit ack_last,
                            output int cont, output int fines, output int avs,
                            output bit alarm_close);
    fines = 0; avs = 0; cont = -1; alarm_close = 0;
    for (int i = 0; i < WIN; i++) begin
      evento = mask[m_pos];
      ack    = ack_last && (m_pos == WIN - 1);
      step();
      if (fine_finestra) begin
        fines++;
        cont = int'(conteggio);
        alarm_close = allarme;
      end
      if (avanza) avs++;
    end
    evento = 1'b0;
    ack    = 1'b0;
  endtask

  // Bring the window back to its first cycle, closing it as a hit
  task automatic align();
    logic [MAXB-1:0] saved;
    saved = soglia;
    soglia = '0;
    for (int i = 0; i < WIN && m_pos != 0; i++) step();
    soglia = saved;
  endtask

  task automatic test_reset();
    int fines;
    rst = 1'b0; stage = '0;
    model_clear();
    step(); step();
    n_total++;
    if ({conteggio, fine_finestra, allarme, avanza} !== 6'b0)
      $display("FAIL reset_outputs: got %b, required 000000", {conteggio, fine_finestra, allarme, avanza});
    else n_pass++;
    rst = 1'b1;
    fines = 0;
    for (int i = 0; i < 25; i++) begin
      evento = 1'($urandom_range(1, 0));
      step();
      if (fine_finestra) fines++;
    end
    evento = 1'b0;
    n_total++;
    if (fines !== 0) $display("FAIL idle_no_fine: saw %0d closes, required 0", fines);
    else n_pass++;
    n_total++;
    if (conteggio !== 3'd0) $display("FAIL idle_conteggio: got %0d, required 0", conteggio);
    else n_pass++;
    n_total++;
    if (mm_cnt !== 0) $display("FAIL idle_model: %0d cycles differ, required 0", mm_cnt);
    else n_pass++;
    mm_cnt = 0;
  endtask

  task automatic test_hits();
    int cont, fines, avs;
    bit al;
    soglia = 3'd4; stage = 3'd1;
    step();
    for (int w = 0; w < 5; w++) begin
      run_window(rand_mask(4), 1'b0, cont, fines, avs, al);
      n_total++;
      if (cont !== 4 || fines !== 1)
        $display("FAIL hit_count: window %0d conteggio=%0d closes=%0d, required 4 and 1", w, cont, fines);
      else n_pass++;
      n_total++;
      if (avs !== ((w == 4) ? 1 : 0))
        $display("FAIL hit_avanza: window %0d pulses=%0d, required %0d", w, avs, (w == 4) ? 1 : 0);
      else n_pass++;
    end
    n_total++;
    if (allarme !== 1'b0) $display("FAIL hit_no_alarm: allarme=%b, required 0", allarme);
    else n_pass++;
    n_total++;
    if (mm_cnt !== 0) $display("FAIL hit_model: %0d cycles differ, required 0", mm_cnt);
    else n_pass++;
    mm_cnt = 0;
  endtask

  task automatic test_miss_alarm();
    int cont, fines, avs;
    bit al;
    soglia = 3'd4;
    for (int w = 0; w < 3; w++) begin
      run_window(rand_mask(2), 1'b0, cont, fines, avs, al);
      n_total++;
      if (al !== (w == 2))
        $display("FAIL miss_alarm: window %0d allarme=%b, required %b", w, al, (w == 2));
      else n_pass++;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_total++;
    if (allarme !== 1'b0) $display("FAIL ack_clear: allarme=%b, required 0", allarme);
    else n_pass++;
    align();
    for (int w = 0; w < 3; w++) run_window(rand_mask(2), 1'b0, cont, fines, avs, al);
    n_total++;
    if (al !== 1'b1) $display("FAIL miss_alarm_again: allarme=%b, required 1", al);
    else n_pass++;
    run_window(rand_mask(1), 1'b1, cont, fines, avs, al);
    n_total++;
    if (al !== 1'b1) $display("FAIL ack_miss_close: allarme=%b, required 1", al);
    else n_pass++;
    n_total++;
    if (mm_cnt !== 0) $display("FAIL miss_model: %0d cycles differ, required 0", mm_cnt);
    else n_pass++;
    mm_cnt = 0;
  endtask

  task automatic test_async_reset();
    evento = 1'b1;
    for (int i = 0; i < 4; i++) step();
    evento = 1'b0;
    rst = 1'b0;
    #1;
    model_clear();
    n_total++;
    if ({conteggio, fine_finestra, allarme, avanza} !== 6'b0)
      $display("FAIL async_reset: got %b, required 000000", {conteggio, fine_finestra, allarme, avanza});
    else n_pass++;
    step(); step();
    rst = 1'b1;
    step();
    n_total++;
    if (mm_cnt !== 0) $display("FAIL reset_model: %0d cycles differ, required 0", mm_cnt);
    else n_pass++;
    mm_cnt = 0;
  endtask

  task automatic test_saturation();
    int cont, fines, avs;
    bit al;
    stage = 3'd1; soglia = 3'd2;
    align();
    run_window({WIN{1'b1}}, 1'b0, cont, fines, avs, al);
    n_total++;
    if (cont !== SATV) $display("FAIL sat_count: conteggio=%0d, required %0d", cont, SATV);
    else n_pass++;
    run_window(10'b1000000000, 1'b0, cont, fines, avs, al);
    n_total++;
    if (cont !== 1) $display("FAIL last_cycle_event: conteggio=%0d, required 1", cont);
    else n_pass++;
    n_total++;
    if (mm_cnt !== 0) $display("FAIL sat_model: %0d cycles differ, required 0", mm_cnt);
    else n_pass++;
    mm_cnt = 0;
  endtask

  task automatic test_stage_change();
    int cont, fines, avs, tot_av, k;
    bit al, got;
    soglia = 3'd4; stage = 3'd2;
    step();
    for (int w = 0; w < 4; w++) run_window(rand_mask(4), 1'b0, cont, fines, avs, al);
    evento = 1'b1;
    for (int i = 0; i < 4; i++) step();
    stage = 3'd3;
    step();
    k = 0; got = 0;
    while (k < 12 && !got) begin
      step();
      k++;
      if (fine_finestra) got = 1;
    end
    evento = 1'b0;
    n_total++;
    if (!got || k !== 10) $display("FAIL stage_restart_close: close after %0d cycles (seen=%b), required 10", k, got);
    else n_pass++;
    tot_av = int'(avanza);
    for (int w = 0; w < 3; w++) begin
      run_window(rand_mask(4), 1'b0, cont, fines, avs, al);
      tot_av += avs;
    end
    n_total++;
    if (tot_av !== 0) $display("FAIL stage_hit_restart: %0d pulses after 4 hits, required 0", tot_av);
    else n_pass++;
    run_window(rand_mask(5), 1'b0, cont, fines, avs, al);
    n_total++;
    if (avs !== 1) $display("FAIL stage_fifth_hit: %0d pulses, required 1", avs);
    else n_pass++;
    stage = 3'(LASTST);
    step();
    tot_av = 0;
    for (int w = 0; w < 6; w++) begin
      run_window(rand_mask(4), 1'b0, cont, fines, avs, al);
      tot_av += avs;
    end
    n_total++;
    if (tot_av !== 0) $display("FAIL last_stage_avanza: %0d pulses, required 0", tot_av);
    else n_pass++;
    n_total++;
    if (mm_cnt !== 0) $display("FAIL stage_model: %0d cycles differ, required 0", mm_cnt);
    else n_pass++;
    mm_cnt = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99, 0) < 3) stage = 3'($urandom_range(LASTST, 0));
      if ($urandom_range(99, 0) < 10) soglia = 3'($urandom_range(SATV, 0));
      evento = ($urandom_range(99, 0) < 30);
      ack    = ($urandom_range(99, 0) < 5);
      step();
    end
    evento = 1'b0; ack = 1'b0;
    n_total++;
    if (mm_cnt !== 0) $display("FAIL random_model: %0d cycles differ, required 0", mm_cnt);
    else n_pass++;
    mm_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss_alarm();
    test_async_reset();
    test_saturation();
    test_stage_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soglia_monitor.md
Name: soglia_monitor

Overview:
- Sits directly downstream of the stage FSM and consumes its `soglia` (threshold) and `stage` outputs.
- Counts patient-activity event pulses over fixed time windows and compares each window's count against `soglia`.
- Raises a latched alarm after repeated under-threshold windows.
- Emits a one-cycle `avanza` pulse after repeated on-target windows; `avanza` is wired back to the stage FSM `incremento` input.

Parameters:
- MAXB, 9, width of `soglia` and of the event counter.
- STAGE, 3, width of `stage`.
- WIN_CYCLES, 100000000, clock cycles per observation window (1 s at 100 MHz); must be ≥ 2.
- WINW, 27, width of the window timer; must satisfy 2^WINW > WIN_CYCLES.
- MISS_MAX, 3, consecutive under-threshold windows that set the alarm.
- HIT_MAX, 5, consecutive on-target windows that produce `avanza`.
- STAGE_LAST, 5, final stage code; no `avanza` is produced in this stage.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- evento  in  1  activity event pulse.
- soglia  in  MAXB  per-window threshold from the stage FSM.
- stage  in  STAGE  current stage code from the stage FSM; 0 means idle.
- ack  in  1  operator alarm acknowledge, level-sampled.
- conteggio  out  MAXB  event count of the last completed window.
- fine_finestra  out  1  one-cycle pulse when a window closes.
- allarme  out  1  latched alarm.
- avanza  out  1  one-cycle advance request to the stage FSM.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0; window timer, event counter, miss counter and hit counter are 0; registered `stage_q` is 0; state is DISABLED.
- States and transitions:
  - DISABLED: entered whenever stage==0. All counters are held at 0 and `allarme` is cleared. Moves to MONITOR on the first cycle with stage!=0.
  - MONITOR: the window timer counts 0..WIN_CYCLES-1.
    - Each qualified event increments the event counter, saturating at 2^MAXB-1.
    - When the timer is at WIN_CYCLES-1, the window closes that cycle. An event arriving in that same cycle is included in the closing window.
    - The next cycle: `conteggio` takes the final count, `fine_finestra`=1, and the timer and event counter restart at 0.
  - ALARM: identical counting to MONITOR, with `allarme`=1. Returns to MONITOR on ack=1.
- Window evaluation, at close, uses `soglia` sampled at the close cycle:
  - Count < soglia: miss counter +1 (saturating at MISS_MAX), hit counter cleared. When the miss counter reaches MISS_MAX, enter ALARM.
  - Count ≥ soglia: hit counter +1, miss counter cleared. When the hit counter reaches HIT_MAX and stage!=STAGE_LAST, `avanza`=1 for exactly one cycle (together with `fine_finestra`) and the hit counter is cleared.
- Stage change (stage!=stage_q while stage!=0):
  - Restart the window: timer and event counter go to 0.
  - Clear the hit and miss counters.
  - Suppress `fine_finestra` and `avanza` that cycle.
  - `allarme` is unchanged.
  - `stage_q` updates every cycle.
- ack:
  - In ALARM: clears `allarme` and the miss counter.
  - If ack coincides with a window close that reaches MISS_MAX, the alarm stays set; the new condition wins.
  - ack in MONITOR has no effect.
- soglia=0: every window counts as a hit.
- `conteggio` holds its value between window closes and is cleared on entry to DISABLED.
- Latency: event to counter is 1 cycle; window close to outputs is 1 cycle.

Optional Feature:
- Macro: EVENT_SYNC_EN.
- Defined: `evento` is asynchronous. It passes through a 2-flop synchronizer followed by a rising-edge detector; a qualified event is one cycle per rising edge, adding 3 cycles of latency.
- Undefined: `evento` is synchronous, and every cycle it is high counts as one event.

Decomposition:
- Shared package `monitor_pkg` holds:
  - state encoding localparams DISABLED, MONITOR, ALARM;
  - STAGE_IDLE=0 and STAGE_LAST=5;
  - default MAXB/STAGE widths shared with the stage FSM.
- One sub-module, `window_timer`: a WIN_CYCLES cycle counter with synchronous restart input and `last` output.

Test Plan (WIN_CYCLES=10, MISS_MAX=3, HIT_MAX=5, EVENT_SYNC_EN undefined):
- Reset release, stage=0, evento toggling -> all outputs stay 0, `conteggio`=0, no `fine_finestra`.
- stage=1, soglia=4, 4 single-cycle events per window for 5 windows -> `conteggio`=4 each window, `avanza` pulses once at the 5th close, `allarme`=0.
- soglia=4, 2 events per window for 3 windows -> `allarme`=1 at the 3rd close; ack=1 -> `allarme`=0 the next cycle.
- evento held high for 10 cycles with MAXB=3 -> `conteggio` saturates at 7; an event in the last window cycle is counted in the closing window.
- stage changes 2→3 mid-window -> no `fine_finestra` that window, next close occurs 10 cycles after the change, hit/miss counters restart; stage=5 with 5 hits -> no `avanza`.
- ack coinciding with the 3rd consecutive miss close -> `allarme` remains 1; rst=0 mid-window -> all outputs 0 immediately.
